// File: rtl/i2c_nios_sysid_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : i2c_nios_sysid_reader                                            |
// | Brief  : Reads the system ID (word 0) and build timestamp (word 1) over   |
// |          an Avalon-MM master port. Compares each word with its expected   |
// |          value. Each access is guarded by a per-access cycle timeout.     |
// | Rev    : 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
module i2c_nios_sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'd2882375689,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1454509112,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ID   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_RD_TS   = 3'd3,
    S_WAIT_TS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] c_TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        accept;
  logic        tmo_hit;

  // The counter value after this cycle; reaching the limit ends the access.
  assign cnt_d   = cnt_q + 16'd1;
  assign accept  = avm_read && !avm_waitrequest;
  assign tmo_hit = (cnt_d == c_TMO_LIMIT);

  // Sequencer: all outputs are registered and updated with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RD_ID;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            cnt_q       <= 16'd0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout     <= 1'b0;
          end
        end

        S_RD_ID: begin
          cnt_q <= cnt_d;
          if (accept && avm_readdatavalid) begin
            // Same-cycle data: skip WAIT_ID and issue the timestamp read.
            id_value    <= avm_readdata;
            id_match    <= (avm_readdata == EXPECTED_ID);
            state_q     <= S_RD_TS;
            avm_address <= 1'b1;
            cnt_q       <= 16'd0;
          end else if (tmo_hit) begin
            state_q  <= S_DONE;
            timeout  <= 1'b1;
            avm_read <= 1'b0;
            done     <= 1'b1;
          end else if (accept) begin
            state_q  <= S_WAIT_ID;
            avm_read <= 1'b0;
          end
        end

        S_WAIT_ID: begin
          cnt_q <= cnt_d;
          if (avm_readdatavalid) begin
            id_value    <= avm_readdata;
            id_match    <= (avm_readdata == EXPECTED_ID);
            state_q     <= S_RD_TS;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            cnt_q       <= 16'd0;
          end else if (tmo_hit) begin
            state_q <= S_DONE;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end

        S_RD_TS: begin
          cnt_q <= cnt_d;
          if (accept && avm_readdatavalid) begin
            ts_value    <= avm_readdata;
            ts_match    <= (avm_readdata == EXPECTED_TIMESTAMP);
            state_q     <= S_DONE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            done        <= 1'b1;
          end else if (tmo_hit) begin
            state_q     <= S_DONE;
            timeout     <= 1'b1;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            done        <= 1'b1;
          end else if (accept) begin
            state_q     <= S_WAIT_TS;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
          end
        end

        S_WAIT_TS: begin
          cnt_q <= cnt_d;
          if (avm_readdatavalid) begin
            ts_value <= avm_readdata;
            ts_match <= (avm_readdata == EXPECTED_TIMESTAMP);
            state_q  <= S_DONE;
            done     <= 1'b1;
          end else if (tmo_hit) begin
            state_q <= S_DONE;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_q     <= S_IDLE;
          busy        <= 1'b0;
          avm_read    <= 1'b0;
          avm_address <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_nios_sysid_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_i2c_nios_sysid_reader                                         |
// | Brief  : Self-checking bench: vector table for zero-wait reads plus      |
// |          hand sequences for stalls, ignored start, reset and timeout.   |
// | Rev    : 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_nios_sysid_reader;

  localparam logic [31:0] c_ID = 32'd2882375689;
  localparam logic [31:0] c_TS = 32'd1454509112;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, wr = 1'b0, rdv = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        addr, rd, busy, done, idm, tsm, to;
  logic [31:0] idv, tsv;

  logic        start_t = 1'b0, wr_t = 1'b0, rdv_t = 1'b0;
  logic [31:0] rdata_t = 32'd0;
  logic        addr_t, rd_t, busy_t, done_t, idm_t, tsm_t, to_t;
  logic [31:0] idv_t, tsv_t;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  i2c_nios_sysid_reader dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(addr), .avm_read(rd), .avm_waitrequest(wr),
    .avm_readdatavalid(rdv), .avm_readdata(rdata),
    .busy(busy), .done(done), .id_value(idv), .ts_value(tsv),
    .id_match(idm), .ts_match(tsm), .timeout(to)
  );

  i2c_nios_sysid_reader #(.TIMEOUT_CYCLES(4)) dut_t (
    .clock(clock), .reset(reset), .start(start_t),
    .avm_address(addr_t), .avm_read(rd_t), .avm_waitrequest(wr_t),
    .avm_readdatavalid(rdv_t), .avm_readdata(rdata_t),
    .busy(busy_t), .done(done_t), .id_value(idv_t), .ts_value(tsv_t),
    .id_match(idm_t), .ts_match(tsm_t), .timeout(to_t)
  );

  typedef struct packed {
    logic        start, wr, rdv;
    logic [31:0] rdata;
    logic        busy, done, rd, addr, idm, tsm, to;
    logic [31:0] idv, tsv;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic w, input logic v, input logic [31:0] d,
                     input logic b, input logic dn, input logic r, input logic a,
                     input logic im, input logic tm, input logic t,
                     input logic [31:0] iv, input logic [31:0] tv);
    vec_t e;
    e.start = s; e.wr = w; e.rdv = v; e.rdata = d;
    e.busy = b; e.done = dn; e.rd = r; e.addr = a;
    e.idm = im; e.tsm = tm; e.to = t; e.idv = iv; e.tsv = tv;
    vq.push_back(e);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // End the current cycle: wait for the edge, then settle just after it.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // One stalled access: 3 waitrequest cycles, accept, data 2 cycles later.
  task automatic stalled_access(input logic exp_addr, input logic [31:0] data,
                                input logic pulse_start);
    for (int k = 0; k < 3; k++) begin
      wr = 1'b1; rdv = 1'b0;
      @(negedge clock);
      chk1("stall_read", rd, 1'b1);
      chk1("stall_addr", addr, exp_addr);
      next_cycle();
    end
    wr = 1'b0;
    @(negedge clock);
    chk1("accept_read", rd, 1'b1);
    chk1("accept_addr", addr, exp_addr);
    next_cycle();
    start = pulse_start;
    @(negedge clock);
    chk1("wait_read", rd, 1'b0);
    chk1("wait_busy", busy, 1'b1);
    next_cycle();
    start = 1'b0; rdv = 1'b1; rdata = data;
    @(negedge clock);
    chk1("wait2_read", rd, 1'b0);
    next_cycle();
    rdv = 1'b0; rdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int done_cnt;

    // Zero-wait responder with same-cycle data, then ID=0, then wrong TS.
    add(1,0,0,32'd0,  0,0,0,0, 0,0,0, 32'd0, 32'd0);
    add(0,0,1,c_ID,   1,0,1,0, 0,0,0, 32'd0, 32'd0);
    add(0,0,1,c_TS,   1,0,1,1, 1,0,0, c_ID,  32'd0);
    add(0,0,0,32'd0,  1,1,0,0, 1,1,0, c_ID,  c_TS);
    add(0,0,0,32'd0,  0,0,0,0, 1,1,0, c_ID,  c_TS);
    add(1,0,0,32'd0,  0,0,0,0, 1,1,0, c_ID,  c_TS);
    add(0,0,1,32'd0,  1,0,1,0, 0,0,0, 32'd0, 32'd0);
    add(0,0,1,c_TS,   1,0,1,1, 0,0,0, 32'd0, 32'd0);
    add(0,0,0,32'd0,  1,1,0,0, 0,1,0, 32'd0, c_TS);
    add(0,0,0,32'd0,  0,0,0,0, 0,1,0, 32'd0, c_TS);
    add(1,0,0,32'd0,  0,0,0,0, 0,1,0, 32'd0, c_TS);
    add(0,0,1,c_ID,   1,0,1,0, 0,0,0, 32'd0, 32'd0);
    add(0,0,1,c_TS ^ 32'd1, 1,0,1,1, 1,0,0, c_ID, 32'd0);
    add(0,0,0,32'd0,  1,1,0,0, 1,0,0, c_ID,  c_TS ^ 32'd1);
    add(0,0,1,32'd7,  0,0,0,0, 1,0,0, c_ID,  c_TS ^ 32'd1);
    add(0,0,0,32'd0,  0,0,0,0, 1,0,0, c_ID,  c_TS ^ 32'd1);

    // Reset state while reset is held.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_read", rd, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_id", idv, 32'd0);
    chk1("rst_t_busy", busy_t, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Table-driven vectors.
    foreach (vq[i]) begin
      start = vq[i].start; wr = vq[i].wr; rdv = vq[i].rdv; rdata = vq[i].rdata;
      @(negedge clock);
      chk1("vec_busy", busy, vq[i].busy);
      chk1("vec_done", done, vq[i].done);
      chk1("vec_read", rd, vq[i].rd);
      chk1("vec_addr", addr, vq[i].addr);
      chk1("vec_idm", idm, vq[i].idm);
      chk1("vec_tsm", tsm, vq[i].tsm);
      chk1("vec_to", to, vq[i].to);
      chk32("vec_idv", idv, vq[i].idv);
      chk32("vec_tsv", tsv, vq[i].tsv);
      next_cycle();
    end
    start = 1'b0; wr = 1'b0; rdv = 1'b0; rdata = 32'd0;

    // Stalled responder; a start pulse during WAIT_TS must be ignored.
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    stalled_access(1'b0, c_ID, 1'b0);
    stalled_access(1'b1, c_TS, 1'b1);
    @(negedge clock);
    chk1("stall_done", done, 1'b1);
    chk1("stall_idm", idm, 1'b1);
    chk1("stall_tsm", tsm, 1'b1);
    chk1("stall_to", to, 1'b0);
    chk32("stall_idv", idv, c_ID);
    chk32("stall_tsv", tsv, c_TS);
    next_cycle();
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (done) done_cnt++;
      next_cycle();
    end
    chk32("extra_done_count", done_cnt, 32'd0);
    chk1("after_busy", busy, 1'b0);

    // Reset asserted in WAIT_ID.
    start = 1'b1;
    next_cycle();
    start = 1'b0; wr = 1'b0; rdv = 1'b0;
    next_cycle();
    @(negedge clock);
    chk1("wait_id_busy", busy, 1'b1);
    chk1("wait_id_read", rd, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_read", rd, 1'b0);
    chk1("midrst_addr", addr, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_idm", idm, 1'b0);
    chk1("midrst_tsm", tsm, 1'b0);
    chk1("midrst_to", to, 1'b0);
    chk32("midrst_idv", idv, 32'd0);
    chk32("midrst_tsv", tsv, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Clean zero-wait sequence after reset.
    start = 1'b1;
    next_cycle();
    start = 1'b0; rdv = 1'b1; rdata = c_ID;
    @(negedge clock);
    chk1("clean_rd_id", rd, 1'b1);
    next_cycle();
    rdata = c_TS;
    @(negedge clock);
    chk1("clean_addr_ts", addr, 1'b1);
    next_cycle();
    rdv = 1'b0; rdata = 32'd0;
    @(negedge clock);
    chk1("clean_done", done, 1'b1);
    chk1("clean_idm", idm, 1'b1);
    chk1("clean_tsm", tsm, 1'b1);
    chk1("clean_to", to, 1'b0);
    next_cycle();

    // Timeout instance: waitrequest stuck high.
    start_t = 1'b1;
    next_cycle();
    start_t = 1'b0; wr_t = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk1("tmo_rd_phase_read", rd_t, 1'b1);
      chk1("tmo_rd_phase_done", done_t, 1'b0);
      next_cycle();
    end
    @(negedge clock);
    chk1("tmo_done", done_t, 1'b1);
    chk1("tmo_flag", to_t, 1'b1);
    chk1("tmo_read", rd_t, 1'b0);
    chk1("tmo_idm", idm_t, 1'b0);
    chk1("tmo_tsm", tsm_t, 1'b0);
    next_cycle();
    wr_t = 1'b0; rdv_t = 1'b1; rdata_t = c_ID;
    @(negedge clock);
    chk1("tmo_idle_busy", busy_t, 1'b0);
    next_cycle();
    rdv_t = 1'b0; rdata_t = 32'd0;
    @(negedge clock);
    chk32("late_idv", idv_t, 32'd0);
    chk1("late_idm", idm_t, 1'b0);
    chk1("late_to_held", to_t, 1'b1);
    chk1("late_done", done_t, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
